// File: rtl/mips_pkg.sv
// Shared loader definitions: memory geometry, header size and loader state encoding.
package mips_pkg;

  localparam int unsigned IMEM_WORDS = 1024;
  localparam int unsigned HDR_BYTES  = 2;

  typedef enum logic [2:0] {
    IDLE,
    HDR_HI,
    HDR_LO,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Big-endian byte-to-word assembler: three held bytes plus the byte being accepted form the word.
module word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        last
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= {sr[15:0], byte_data};
      cnt <= cnt + 2'd1;
    end
  end

  // Word is complete in the same cycle the fourth byte is offered.
  assign word = {sr, byte_data};
  assign last = (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program into instruction memory while holding the CPU in reset.
module imem_loader
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = mips_pkg::IMEM_WORDS,
  parameter int unsigned HDR_BYTES  = mips_pkg::HDR_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = $clog2(IMEM_WORDS) + 1;
  localparam int unsigned CNT_W = 8 * HDR_BYTES;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] hdr_next;
  logic [IDX_W-1:0] index;
  logic             accept;
  logic             asm_last;
  logic             last_word;
  logic [31:0]      asm_word;

  assign accept    = byte_valid && byte_ready;
  assign hdr_next  = {count[CNT_W-9:0], byte_data};
  assign last_word = (32'(index) + 32'd1) == 32'(count);

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (state != DATA),
    .accept    (accept && (state == DATA)),
    .byte_data (byte_data),
    .word      (asm_word),
    .last      (asm_last)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = HDR_HI;
      HDR_HI: if (accept) state_next = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_next == '0)
            state_next = DONE;
          else if (32'(hdr_next) > IMEM_WORDS)
            state_next = ERROR;
          else
            state_next = DATA;
        end
      end
      DATA:   if (accept && asm_last) state_next = WRITE;
      WRITE:  state_next = last_word ? DONE : DATA;
      DONE,
      ERROR:  if (start) state_next = HDR_HI;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from state_next so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      index      <= '0;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && ((state == HDR_HI) || (state == HDR_LO)))
        count <= hdr_next;
      if (state_next == HDR_HI)
        index <= '0;
      else if ((state == WRITE) && !last_word)
        index <= index + 1'b1;
      byte_ready <= (state_next == HDR_HI) || (state_next == HDR_LO) || (state_next == DATA);
      mem_we     <= (state_next == WRITE);
      if (state_next == WRITE) begin
        mem_addr  <= 32'({index, 2'b00});
        mem_wdata <= asm_word;
      end
      cpu_hold <= (state_next != DONE);
      done     <= (state_next == DONE);
      error    <= (state_next == ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader: table of per-cycle stimulus/expectations plus a full-depth load.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, cpu_hold, done, error;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.IMEM_WORDS(1024), .HDR_BYTES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef enum {E_IDLE, E_BUSY, E_DONE, E_ERR, E_WRITE} exp_t;

  typedef struct {
    string       name;
    bit          rst, st, bv;
    logic [7:0]  d;
    exp_t        exp;
    bit          chk_mem;
    logic [31:0] a, wd;
  } vec_t;

  vec_t        vecs[$];
  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned we_cnt = 0;
  int unsigned bad_addr = 0;
  int unsigned exp_writes = 0;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_cnt++;
      if (mem_addr >= 32'h1000) bad_addr++;
    end
  end

  task automatic add(input string n, input bit rst, st, bv, input logic [7:0] d,
                     input exp_t e, input logic [31:0] a, wd);
    vec_t v;
    v.name = n; v.rst = rst; v.st = st; v.bv = bv; v.d = d; v.exp = e;
    v.chk_mem = rst || (e == E_WRITE);
    v.a = a; v.wd = wd;
    vecs.push_back(v);
  endtask

  task automatic cyc(input string n, input bit st, bv, input logic [7:0] d, input exp_t e);
    add(n, 1'b0, st, bv, d, e, '0, '0);
  endtask

  task automatic wr(input string n, input bit st, input logic [7:0] d, input logic [31:0] a, wd);
    add(n, 1'b0, st, 1'b1, d, E_WRITE, a, wd);
  endtask

  task automatic rs(input string n, input bit st, bv, input logic [7:0] d);
    add(n, 1'b1, st, bv, d, E_IDLE, '0, '0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input exp_t e, input bit chk_mem, input logic [31:0] a, wd);
    logic r, w, h, dn, er;
    bit   ok;
    case (e)
      E_IDLE:  begin r = 0; w = 0; h = 1; dn = 0; er = 0; end
      E_BUSY:  begin r = 1; w = 0; h = 1; dn = 0; er = 0; end
      E_DONE:  begin r = 0; w = 0; h = 0; dn = 1; er = 0; end
      E_ERR:   begin r = 0; w = 0; h = 1; dn = 0; er = 1; end
      default: begin r = 0; w = 1; h = 1; dn = 0; er = 0; end
    endcase
    nvec++;
    ok = (byte_ready === r) && (mem_we === w) && (cpu_hold === h) && (done === dn) && (error === er);
    if (chk_mem) ok = ok && (mem_addr === a) && (mem_wdata === wd);
    if (!ok) begin
      nerr++;
      $display("FAIL %s: got rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h; want rdy=%b we=%b hold=%b done=%b err=%b addr=%h data=%h",
               n, byte_ready, mem_we, cpu_hold, done, error, mem_addr, mem_wdata,
               r, w, h, dn, er, chk_mem ? a : mem_addr, chk_mem ? wd : mem_wdata);
    end
  endtask

  task automatic check_int(input string n, input int unsigned got, want);
    nvec++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", n, got, want);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0;

    rs("reset0", 0, 0, 8'h00);
    rs("reset1", 0, 0, 8'h00);
    cyc("idle_ignores_byte", 0, 1, 8'hAA, E_IDLE);
    // two-word program
    cyc("start", 1, 0, 8'h00, E_BUSY);
    cyc("hdr_hi", 0, 1, 8'h00, E_BUSY);
    cyc("hdr_lo", 0, 1, 8'h02, E_BUSY);
    cyc("w0b0", 0, 1, 8'h20, E_BUSY);
    cyc("w0b1", 0, 1, 8'h08, E_BUSY);
    cyc("w0b2", 0, 1, 8'h00, E_BUSY);
    wr("w0_write", 0, 8'h05, 32'h0, 32'h20080005);
    cyc("write_ignores_byte", 0, 1, 8'hFF, E_BUSY);
    cyc("w1b0", 0, 1, 8'hAC, E_BUSY);
    cyc("w1b1", 0, 1, 8'h08, E_BUSY);
    cyc("w1b2", 0, 1, 8'h00, E_BUSY);
    wr("w1_write", 0, 8'h00, 32'h4, 32'hAC080000);
    cyc("done", 0, 0, 8'h00, E_DONE);
    cyc("done_holds", 0, 1, 8'h33, E_DONE);
    // zero length, then oversize header
    cyc("restart_from_done", 1, 0, 8'h00, E_BUSY);
    cyc("zlen_hi", 0, 1, 8'h00, E_BUSY);
    cyc("zero_len_done", 0, 1, 8'h00, E_DONE);
    cyc("start_big", 1, 0, 8'h00, E_BUSY);
    cyc("big_hi", 0, 1, 8'h04, E_BUSY);
    cyc("len_1025_error", 0, 1, 8'h01, E_ERR);
    cyc("error_holds", 0, 1, 8'h55, E_ERR);
    // gapped byte_valid
    cyc("start_from_error", 1, 0, 8'h00, E_BUSY);
    cyc("g_hi", 0, 1, 8'h00, E_BUSY);
    cyc("g_lo", 0, 1, 8'h01, E_BUSY);
    cyc("g_b0", 0, 1, 8'h12, E_BUSY);
    cyc("g_gap0", 0, 0, 8'hEE, E_BUSY);
    cyc("g_b1", 0, 1, 8'h34, E_BUSY);
    cyc("g_gap1", 0, 0, 8'hEE, E_BUSY);
    cyc("g_b2", 0, 1, 8'h56, E_BUSY);
    cyc("g_gap2", 0, 0, 8'hEE, E_BUSY);
    wr("gapped_write", 0, 8'h78, 32'h0, 32'h12345678);
    cyc("g_done", 0, 0, 8'h00, E_DONE);
    // start pulses mid-session are ignored
    cyc("s_start", 1, 0, 8'h00, E_BUSY);
    cyc("s_hi", 0, 1, 8'h00, E_BUSY);
    cyc("s_lo", 0, 1, 8'h02, E_BUSY);
    cyc("s_b0", 0, 1, 8'h11, E_BUSY);
    cyc("start_in_data", 1, 1, 8'h22, E_BUSY);
    cyc("s_b2", 0, 1, 8'h33, E_BUSY);
    wr("s_w0", 0, 8'h44, 32'h0, 32'h11223344);
    cyc("start_in_write", 1, 0, 8'h00, E_BUSY);
    cyc("s_b4", 0, 1, 8'h55, E_BUSY);
    cyc("s_b5", 0, 1, 8'h66, E_BUSY);
    cyc("s_b6", 0, 1, 8'h77, E_BUSY);
    wr("s_w1", 0, 8'h88, 32'h4, 32'h55667788);
    cyc("s_done", 0, 0, 8'h00, E_DONE);
    // reset mid-word beats start and a byte in the same cycle
    cyc("r_start", 1, 0, 8'h00, E_BUSY);
    cyc("r_hi", 0, 1, 8'h00, E_BUSY);
    cyc("r_lo", 0, 1, 8'h01, E_BUSY);
    cyc("r_b0", 0, 1, 8'hAB, E_BUSY);
    cyc("r_b1", 0, 1, 8'hCD, E_BUSY);
    rs("reset_mid_word", 1, 1, 8'hEF);
    cyc("idle_after_reset", 0, 1, 8'h11, E_IDLE);
    cyc("f_start", 1, 0, 8'h00, E_BUSY);
    cyc("f_hi", 0, 1, 8'h00, E_BUSY);
    cyc("f_lo", 0, 1, 8'h01, E_BUSY);
    cyc("f_b0", 0, 1, 8'hDE, E_BUSY);
    cyc("f_b1", 0, 1, 8'hAD, E_BUSY);
    cyc("f_b2", 0, 1, 8'hBE, E_BUSY);
    wr("fresh_write", 0, 8'hEF, 32'h0, 32'hDEADBEEF);
    cyc("f_done", 0, 0, 8'h00, E_DONE);

    foreach (vecs[i]) if (vecs[i].exp == E_WRITE) exp_writes++;
    exp_writes += 1024;

    #1;
    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      start      = vecs[i].st;
      byte_valid = vecs[i].bv;
      byte_data  = vecs[i].d;
      tick();
      check(vecs[i].name, vecs[i].exp, vecs[i].chk_mem, vecs[i].a, vecs[i].wd);
    end

    // full-depth load: 1024 words, header 0x0400
    reset = 0; start = 1; byte_valid = 0; byte_data = '0;
    tick(); check("full_start", E_BUSY, 0, '0, '0);
    start = 0; byte_valid = 1; byte_data = 8'h04;
    tick();
    byte_data = 8'h00;
    tick(); check("full_hdr_1024_accepted", E_BUSY, 0, '0, '0);
    for (int unsigned i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = 32'hC0DE0000 | i;
      for (int unsigned b = 0; b < 4; b++) begin
        byte_valid = 1;
        byte_data  = w[31 - 8*b -: 8];
        tick();
      end
      check($sformatf("full_write_%0d", i), E_WRITE, 1, i * 4, w);
      byte_data = 8'hFF;
      tick();
      check($sformatf("full_after_%0d", i), (i == 1023) ? E_DONE : E_BUSY, 0, '0, '0);
    end
    byte_valid = 0;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      check("full_done_idle", E_DONE, 1, 32'hFFC, 32'hC0DE03FF);
    end

    check_int("total_writes", we_cnt, exp_writes);
    check_int("addr_out_of_range", bad_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter IMEM_WORDS, 1024, instruction memory depth in 32-bit words.
REQ-002 Parameter HDR_BYTES, 2, length-header size in bytes, big-endian.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse that begins a load session.
REQ-006 byte_valid  input  1  byte_data holds a valid byte this cycle.
REQ-007 byte_data  input  8  program byte stream.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
REQ-009 mem_we  output  1  one-cycle write strobe to instruction memory write port.
REQ-010 mem_addr  output  32  byte address of word written; always word-aligned, bits[1:0]=0.
REQ-011 mem_wdata  output  32  instruction word written.
REQ-012 cpu_hold  output  1  holds processor PC/fetch in reset while loading.
REQ-013 done  output  1  level; last session completed without error.
REQ-014 error  output  1  level; last session aborted on header error.

Function
REQ-015 States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERROR.
REQ-016 IDLE: start moves to HDR_HI; byte_valid is ignored.
REQ-017 HDR_HI/HDR_LO: each accepted byte loads count[15:8] then count[7:0].
REQ-018 After HDR_LO: count=0 -> DONE; count>IMEM_WORDS -> ERROR; otherwise -> DATA with word index 0.
REQ-019 DATA: accepted bytes assemble big-endian (first byte -> bits[31:24]); 4th accepted byte -> WRITE.
REQ-020 WRITE lasts exactly one cycle: mem_we=1, mem_addr=index<<2, mem_wdata=assembled word; byte_ready=0.
REQ-021 After WRITE: index+1==count -> DONE, else index increments and returns to DATA.
REQ-022 Latency: mem_we asserts the cycle after the 4th byte of a word is accepted.
REQ-023 byte_ready=1 only in HDR_HI, HDR_LO, DATA; gaps in byte_valid stall without losing partial words.
REQ-024 start while in HDR_HI, HDR_LO, DATA or WRITE is ignored.
REQ-025 start in DONE or ERROR clears done/error, clears index and byte counter, enters HDR_HI.
REQ-026 cpu_hold=1 in every state except DONE; ERROR keeps cpu_hold=1.
REQ-027 mem_we is never asserted outside WRITE; max address written = (count-1)*4, never >= IMEM_WORDS*4.
REQ-028 Index counter is clog2(IMEM_WORDS)+1 bits wide; no wrap-around permitted.

Reset
REQ-029 reset forces IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0.
REQ-030 reset mid-session discards the partial word and header; already-written words remain in memory.
REQ-031 reset has priority over start and byte transfers in the same cycle.

Structure
REQ-032 State encoding, IMEM_WORDS and HDR_BYTES belong in shared package mips_pkg.
REQ-033 Byte-to-word shift register plus 2-bit byte counter is one natural sub-module: word_assembler.
REQ-034 The FSM, index counter and output registers stay in imem_loader; all outputs registered.

Verification
REQ-035 start; header 0x00,0x02; bytes 20,08,00,05,AC,08,00,00 -> mem_we at 0x0 data 0x20080005, then 0x4 data 0xAC080000; done=1, cpu_hold=0.
REQ-036 header 0x00,0x00 -> DONE with no mem_we; header 0x04,0x01 (1025) -> error=1, cpu_hold=1, no writes.
REQ-037 byte_valid toggled 1-0-1-0 during a word -> same word 0x12345678 written once, one cycle after 4th byte.
REQ-038 start pulsed during DATA -> ignored, index continues; start in DONE -> done=0, cpu_hold=1, HDR_HI.
REQ-039 reset after 2 data bytes -> IDLE, cpu_hold=1, no mem_we; fresh session writes index 0 correctly.
REQ-040 Full 1024-word load (header 0x04,0x00) -> last write at 0xFFC, done=1, no write at 0x1000.
